// File: rtl/axi_lite_master_fifo_pkg.sv
// Shared definitions for the AXI4-Lite command-FIFO master.
// Holds the AXI response codes, the master FSM state encoding and the FIFO
// almost-full threshold (free entries at or below which almost_full asserts).
package axi_lite_master_fifo_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int ALMOST_FULL_THRESHOLD = 3;

  typedef enum logic [2:0] {
    IDLE,
    WREQ,
    WRESP,
    RREQ,
    RRESP
  } state_t;

  // Any response other than OKAY counts as an error, EXOKAY included,
  // since an AXI4-Lite slave has no exclusive access to report.
  function automatic logic resp_is_error(input logic [1:0] resp);
    logic err;
    case (resp)
      RESP_OKAY:                             err = 1'b0;
      RESP_EXOKAY, RESP_SLVERR, RESP_DECERR: err = 1'b1;
      default:                               err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/axi_lite_master_data_fifo.sv
// Generic first-word-fall-through FIFO, 2**ADDR_WIDTH entries of WIDTH bits.
// Latency: an entry written on one edge is visible at deq_data after that edge.
// Backpressure: enq while full is dropped, deq while empty is ignored.
// Ports: clk/rst_n (synchronous active-low), enq/enq_data write side,
//        deq/deq_data read side (deq_data is the combinational head),
//        empty, almost_full (ALMOST_FULL_THRESHOLD or fewer free entries).
module axi_lite_master_data_fifo
  import axi_lite_master_fifo_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic [WIDTH-1:0] deq_data,
  output logic             empty,
  output logic             almost_full
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  do_enq;
  logic                  do_deq;

  assign full        = (count == (ADDR_WIDTH + 1)'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= (ADDR_WIDTH + 1)'(DEPTH - ALMOST_FULL_THRESHOLD));
  assign do_enq      = enq && !full;
  assign do_deq      = deq && !empty;
  assign deq_data    = mem[rd_ptr];

  // Pointers are exactly ADDR_WIDTH bits, so they wrap from DEPTH-1 to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: empty/count guard every read of stale entries.
  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_data;
  end

endmodule

// File: rtl/axi_lite_master_fifo.sv
// AXI4-Lite master fed by a command FIFO; read data returned through a second FIFO.
// Latency: command pop to AW/W/AR valid is 1 cycle; read data visible 1 cycle after R handshake.
// Backpressure: one transaction in flight; reads stall in IDLE while the read-data FIFO is almost full.
// Ports: ACLK, ARESETN (synchronous active-low); user_cmd_* command push side with
//        user_cmd_almost_full; user_read_* read-data pop side; busy (FSM not IDLE);
//        ERROR (sticky bad response); M_AXI_* AXI4-Lite master channels.
// Build option: define AXI_LITE_MASTER_RESP_CHECK_EN to make ERROR track non-OKAY
//        BRESP/RRESP; otherwise ERROR is tied low and responses are ignored.
module axi_lite_master_fifo
  import axi_lite_master_fifo_pkg::*;
#(
  parameter int FIFO_ADDR_WIDTH    = 4,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  // command side
  input  logic                            user_cmd_enq,
  input  logic                            user_cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   user_cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   user_cmd_wdata,
  output logic                            user_cmd_almost_full,
  // read-data side
  input  logic                            user_read_deq,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   user_read_data,
  output logic                            user_read_empty,
  // status
  output logic                            busy,
  output logic                            ERROR,
  // write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  // write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  // write response channel
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  // read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  // read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int CMD_W = 1 + AW + DW;

  state_t           state;
  state_t           state_nxt;

  logic [CMD_W-1:0] cmd_in;
  logic [CMD_W-1:0] cmd_head;
  logic             cmd_empty;
  logic             cmd_deq;
  logic             head_write;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_wdata;

  logic             rd_enq;
  logic             rd_almost_full;

  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic             aw_done;
  logic             w_done;

  // Command word layout: {write, addr, wdata}.
  assign cmd_in     = {user_cmd_write, user_cmd_addr, user_cmd_wdata};
  assign head_write = cmd_head[CMD_W-1];
  assign head_addr  = cmd_head[DW +: AW];
  assign head_wdata = cmd_head[DW-1:0];

  axi_lite_master_data_fifo #(
    .WIDTH      (CMD_W),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_cmd_fifo (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .enq         (user_cmd_enq),
    .enq_data    (cmd_in),
    .deq         (cmd_deq),
    .deq_data    (cmd_head),
    .empty       (cmd_empty),
    .almost_full (user_cmd_almost_full)
  );

  axi_lite_master_data_fifo #(
    .WIDTH      (DW),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_rd_fifo (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .enq         (rd_enq),
    .enq_data    (M_AXI_RDATA),
    .deq         (user_read_deq),
    .deq_data    (user_read_data),
    .empty       (user_read_empty),
    .almost_full (rd_almost_full)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cmd_deq       = 1'b0;
    rd_enq        = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (state)
      IDLE: begin
        if (!cmd_empty) begin
          if (head_write) begin
            cmd_deq   = 1'b1;
            state_nxt = WREQ;
          end else if (!rd_almost_full) begin
            // Reserve room for the returning word before issuing the read.
            cmd_deq   = 1'b1;
            state_nxt = RREQ;
          end
        end
      end
      WREQ: begin
        // AW and W complete independently; each drops after its own handshake.
        M_AXI_AWVALID = !aw_done;
        M_AXI_WVALID  = !w_done;
        if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY)) begin
          state_nxt = WRESP;
        end
      end
      WRESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) state_nxt = IDLE;
      end
      RREQ: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) state_nxt = RRESP;
      end
      RRESP: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) begin
          rd_enq    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction registers: loaded on pop and held, so address/data stay
  // stable for the whole time any VALID is waiting on READY.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      addr_q  <= '0;
      wdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (cmd_deq) begin
        addr_q  <= head_addr;
        wdata_q <= head_wdata;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (state == WREQ) begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done <= 1'b1;
        if (M_AXI_WVALID && M_AXI_WREADY)   w_done  <= 1'b1;
      end
    end
  end

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = '1;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign busy         = (state != IDLE);

`ifdef AXI_LITE_MASTER_RESP_CHECK_EN
  logic error_q;

  // Sticky until reset; read data is still enqueued on a bad RRESP.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      error_q <= 1'b0;
    end else if ((state == WRESP && M_AXI_BVALID && resp_is_error(M_AXI_BRESP)) ||
                 (state == RRESP && M_AXI_RVALID && resp_is_error(M_AXI_RRESP))) begin
      error_q <= 1'b1;
    end
  end

  assign ERROR = error_q;
`else
  logic resp_unused;

  assign resp_unused = ^{M_AXI_BRESP, M_AXI_RRESP};
  assign ERROR       = 1'b0;
`endif

endmodule
